// File: rtl/picorv32_core.sv
// Multi-cycle RV32I core with one shared valid/ready memory port; halts on trap.
// Config macro PICORV32_MUL_EN builds the iterative shift-add MUL unit.
module picorv32_core #(
   parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        trap,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic [2:0]  dbg_state
);

   // Handshake: a transfer completes on the rising edge where mem_valid and
   // mem_ready are both high; addr/wdata/wstrb/instr hold while mem_valid is high.
   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_MULT, S_TRAP} state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_instr_q, mem_instr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        trap_q, trap_d;
   logic [1:0]  ls_lo_q, ls_lo_d;
`ifdef PICORV32_MUL_EN
   logic [31:0] mul_acc_q, mul_acc_d;
   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic [4:0]  mul_cnt_q, mul_cnt_d;
`endif

   logic [31:0] regs [0:31];
   logic        rf_we;
   logic [31:0] rf_wdata;
   logic        fault;

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] pc_plus4, op_b, alu_res, ls_addr, ld_shift, ld_val;
   logic [31:0] jal_tgt, jalr_tgt, br_tgt;
   logic [4:0]  shamt;
   logic        br_taken, br_ok;

   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign f3     = instr_q[14:12];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign f7     = instr_q[31:25];

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_u = {instr_q[31:12], 12'd0};
   assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

   assign pc_plus4 = pc_q + 32'd4;
   assign jal_tgt  = pc_q + imm_j;
   assign jalr_tgt = (rs1_val + imm_i) & 32'hFFFF_FFFE;
   assign br_tgt   = pc_q + imm_b;
   assign ls_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

   assign op_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = 32'd0;
      case (f3)
         3'b000: alu_res = (opcode == OPC_OP && f7[5]) ? rs1_val - op_b : rs1_val + op_b;
         3'b001: alu_res = rs1_val << shamt;
         3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
         3'b011: alu_res = {31'd0, rs1_val < op_b};
         3'b100: alu_res = rs1_val ^ op_b;
         3'b101: alu_res = f7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110: alu_res = rs1_val | op_b;
         3'b111: alu_res = rs1_val & op_b;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      br_ok    = 1'b1;
      case (f3)
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
         3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  br_taken = (rs1_val < rs2_val);
         3'b111:  br_taken = (rs1_val >= rs2_val);
         default: br_ok = 1'b0;
      endcase
   end

   // Byte offset of the access is kept from EXEC since mem_addr is word aligned.
   assign ld_shift = mem_rdata >> {ls_lo_q, 3'b000};
   always_comb begin
      case (f3)
         3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_val = {24'd0, ld_shift[7:0]};
         3'b101:  ld_val = {16'd0, ld_shift[15:0]};
         default: ld_val = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      mem_valid_d = mem_valid_q;
      mem_instr_d = mem_instr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      trap_d      = trap_q;
      ls_lo_d     = ls_lo_q;
      rf_we       = 1'b0;
      rf_wdata    = 32'd0;
      fault       = 1'b0;
`ifdef PICORV32_MUL_EN
      mul_acc_d   = mul_acc_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_cnt_d   = mul_cnt_q;
`endif
      case (state_q)
         S_FETCH: begin
            if (!mem_valid_q) begin
               mem_valid_d = 1'b1;
               mem_instr_d = 1'b1;
               mem_addr_d  = pc_q;
               mem_wstrb_d = 4'b0000;
            end else if (mem_ready) begin
               mem_valid_d = 1'b0;
               instr_d     = mem_rdata;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_plus4;
            case (opcode)
               OPC_LUI: begin
                  rf_we = 1'b1; rf_wdata = imm_u;
               end
               OPC_AUIPC: begin
                  rf_we = 1'b1; rf_wdata = pc_q + imm_u;
               end
               OPC_JAL: begin
                  rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = jal_tgt;
                  fault = jal_tgt[1];
               end
               OPC_JALR: begin
                  rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = jalr_tgt;
                  fault = jalr_tgt[1] || (f3 != 3'b000);
               end
               OPC_BRANCH: begin
                  fault = !br_ok || (br_taken && br_tgt[1]);
                  if (br_taken) pc_d = br_tgt;
               end
               OPC_LOAD: begin
                  fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
                          || (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00)
                          || (f3[1:0] == 2'b01 && ls_addr[0]);
                  state_d     = S_MEM;
                  mem_valid_d = 1'b1;
                  mem_instr_d = 1'b0;
                  mem_addr_d  = {ls_addr[31:2], 2'b00};
                  mem_wstrb_d = 4'b0000;
                  ls_lo_d     = ls_addr[1:0];
               end
               OPC_STORE: begin
                  fault = f3[2] || (f3[1:0] == 2'b11)
                          || (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00)
                          || (f3[1:0] == 2'b01 && ls_addr[0]);
                  state_d     = S_MEM;
                  mem_valid_d = 1'b1;
                  mem_instr_d = 1'b0;
                  mem_addr_d  = {ls_addr[31:2], 2'b00};
                  ls_lo_d     = ls_addr[1:0];
                  case (f3[1:0])
                     2'b00: begin
                        mem_wdata_d = {4{rs2_val[7:0]}};
                        mem_wstrb_d = 4'b0001 << ls_addr[1:0];
                     end
                     2'b01: begin
                        mem_wdata_d = {2{rs2_val[15:0]}};
                        mem_wstrb_d = 4'b0011 << ls_addr[1:0];
                     end
                     default: begin
                        mem_wdata_d = rs2_val;
                        mem_wstrb_d = 4'b1111;
                     end
                  endcase
               end
               OPC_OPIMM: begin
                  fault = (f3 == 3'b001 && f7 != 7'b0000000)
                          || (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
                  rf_we = 1'b1; rf_wdata = alu_res;
               end
               OPC_OP: begin
                  if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                     rf_we = 1'b1; rf_wdata = alu_res;
                  end
`ifdef PICORV32_MUL_EN
                  else if (f7 == 7'b0000001 && f3 == 3'b000) begin
                     state_d   = S_MULT;
                     mul_acc_d = 32'd0;
                     mul_a_d   = rs1_val;
                     mul_b_d   = rs2_val;
                     mul_cnt_d = 5'd0;
                  end
`endif
                  else begin
                     fault = 1'b1;
                  end
               end
               OPC_FENCE: fault = (f3 != 3'b000);
               default:   fault = 1'b1;
            endcase
            // A faulting instruction leaves pc, registers and the bus untouched.
            if (fault) begin
               state_d     = S_TRAP;
               trap_d      = 1'b1;
               pc_d        = pc_q;
               rf_we       = 1'b0;
               mem_valid_d = 1'b0;
               mem_wstrb_d = 4'b0000;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = S_FETCH;
               if (opcode == OPC_LOAD) begin
                  rf_we = 1'b1; rf_wdata = ld_val;
               end
            end
         end
`ifdef PICORV32_MUL_EN
         S_MULT: begin
            mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : 32'd0);
            mul_a_d   = mul_a_q << 1;
            mul_b_d   = mul_b_q >> 1;
            mul_cnt_d = mul_cnt_q + 5'd1;
            if (mul_cnt_q == 5'd31) begin
               rf_we    = 1'b1;
               rf_wdata = mul_acc_d;
               state_d  = S_FETCH;
            end
         end
`endif
         S_TRAP: begin
            trap_d      = 1'b1;
            mem_valid_d = 1'b0;
         end
         default: begin
            state_d     = S_TRAP;
            trap_d      = 1'b1;
            mem_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_FETCH;
         pc_q        <= PROGADDR_RESET;
         instr_q     <= 32'd0;
         mem_valid_q <= 1'b0;
         mem_instr_q <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_wstrb_q <= 4'b0000;
         trap_q      <= 1'b0;
         ls_lo_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         mem_valid_q <= mem_valid_d;
         mem_instr_q <= mem_instr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         trap_q      <= trap_d;
         ls_lo_q     <= ls_lo_d;
      end
   end

`ifdef PICORV32_MUL_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mul_acc_q <= 32'd0;
         mul_a_q   <= 32'd0;
         mul_b_q   <= 32'd0;
         mul_cnt_q <= 5'd0;
      end else begin
         mul_acc_q <= mul_acc_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end
`endif

   // Register file has no reset; x0 is never written and always reads as zero.
   always_ff @(posedge clk) begin
      if (rf_we && rd != 5'd0) regs[rd] <= rf_wdata;
   end

   assign trap      = trap_q;
   assign mem_valid = mem_valid_q;
   assign mem_instr = mem_instr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_picorv32_core.sv
// Directed bench for picorv32_core: memory responder with random ready delay,
// transaction logs, and hand-computed expectations for each program.
module tb_picorv32_core;

   logic        clk;
   logic        resetn;
   logic        trap;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic [2:0]  dbg_state;

   logic [31:0] mem [0:255];
   logic [31:0] fetch_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] wr_strb_q[$];
   logic [31:0] exp_q[$];
   bit          resp_en;
   int          n_checks;
   int          n_errors;

   picorv32_core #(.PROGADDR_RESET(32'h0000_0000)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .trap      (trap),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: ready is decided on the falling edge, so a transfer
   // granted here completes on the following rising edge and is logged now.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (resp_en && resetn && mem_valid && $urandom_range(0, 2) != 0) begin
            mem_ready = 1'b1;
            if (mem_wstrb == 4'b0000) begin
               mem_rdata = mem[mem_addr[9:2]];
               if (mem_instr) fetch_q.push_back(mem_addr);
               else           rd_q.push_back(mem_addr);
            end else begin
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
               wr_addr_q.push_back(mem_addr);
               wr_data_q.push_back(mem_wdata);
               wr_strb_q.push_back({28'd0, mem_wstrb});
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      fetch_q.delete();
      rd_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_strb_q.delete();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask

   task automatic reset_core(input int cycles);
      resetn = 1'b0;
      clear_logs();
      repeat (cycles) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic wait_writes(input string tag, input int n, input int budget);
      int c = 0;
      while (wr_data_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(tag, {31'd0, wr_data_q.size() >= n}, 32'd1);
   endtask

   task automatic wait_trap(input string tag, input int budget);
      int c = 0;
      while (!trap && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(tag, {31'd0, trap}, 32'd1);
   endtask

   task automatic load_counter_prog();
      clear_mem();
      mem[0] = 32'h3fc00093;
      mem[1] = 32'h0000a023;
      mem[2] = 32'h0000a103;
      mem[3] = 32'h00110113;
      mem[4] = 32'h0020a023;
      mem[5] = 32'hff5ff06f;
   endtask

   initial begin
      logic [31:0] fetch_exp [0:6];
      int          v;
      n_checks = 0;
      n_errors = 0;
      resp_en  = 1'b1;
      resetn   = 1'b0;
      fetch_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h8};

      // Reset held for 100 cycles, then first fetch
      load_counter_prog();
      clear_logs();
      repeat (100) @(negedge clk);
      check("rst_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_trap",  {31'd0, trap}, 32'd0);
      check("rst_addr",  mem_addr, 32'd0);
      check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("fetch0_valid", {31'd0, mem_valid}, 32'd1);
      check("fetch0_addr",  mem_addr, 32'd0);
      check("fetch0_instr", {31'd0, mem_instr}, 32'd1);
      check("fetch0_wstrb", {28'd0, mem_wstrb}, 32'd0);

      // Counter loop: stores 0, 1, 2, 3 to 0x3FC
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
      wait_writes("cnt_done", 4, 3000);
      for (int i = 0; i < 4; i++) begin
         check("cnt_waddr", wr_addr_q[i], 32'h3FC);
         check("cnt_wdata", wr_data_q[i], exp_q.pop_front());
         check("cnt_wstrb", wr_strb_q[i], 32'hF);
      end
      check("cnt_nreads", {31'd0, rd_q.size() >= 3}, 32'd1);
      check("cnt_raddr", rd_q[0], 32'h3FC);
      for (int i = 0; i < 7; i++) check("cnt_fetch", fetch_q[i], fetch_exp[i]);

      // Byte store and signed/unsigned byte loads
      clear_mem();
      mem[0] = 32'h10000093;  // addi x1,x0,0x100
      mem[1] = 32'h08000113;  // addi x2,x0,0x80
      mem[2] = 32'h002080A3;  // sb   x2,1(x1)
      mem[3] = 32'h00108183;  // lb   x3,1(x1)
      mem[4] = 32'h0010C203;  // lbu  x4,1(x1)
      mem[5] = 32'h00302023;  // sw   x3,0(x0)
      mem[6] = 32'h00402223;  // sw   x4,4(x0)
      mem[7] = 32'h0000006F;  // jal  x0,0
      reset_core(5);
      wait_writes("byte_done", 3, 3000);
      check("sb_addr",  wr_addr_q[0], 32'h100);
      check("sb_wstrb", wr_strb_q[0], 32'h2);
      check("sb_wdata", wr_data_q[0], 32'h80808080);
      check("sb_mem",   mem[64], 32'h00008000);
      check("lb_val",   wr_data_q[1], 32'hFFFFFF80);
      check("lb_addr",  wr_addr_q[1], 32'h0);
      check("lbu_val",  wr_data_q[2], 32'h00000080);
      check("lbu_addr", wr_addr_q[2], 32'h4);
      check("rd_byte_addr", rd_q[0], 32'h100);

      // Multiply, or trap on the MUL encoding when the unit is not built
      clear_mem();
      mem[0] = 32'h3fc00093;
      mem[1] = 32'h00200113;
      mem[2] = 32'h02208233;
      mem[3] = 32'h00402023;
      mem[4] = 32'h0000006F;
      reset_core(5);
`ifdef PICORV32_MUL_EN
      wait_writes("mul_done", 1, 3000);
      check("mul_addr",  wr_addr_q[0], 32'h0);
      check("mul_wdata", wr_data_q[0], 32'h000007F8);
      check("mul_wstrb", wr_strb_q[0], 32'hF);
      check("mul_trap",  {31'd0, trap}, 32'd0);
`else
      wait_trap("mul_trap", 1000);
      check("mul_nwrites", wr_data_q.size(), 32'd0);
      check("mul_nfetch",  fetch_q.size(), 32'd3);
`endif

      // All-zero instruction traps and the bus stays idle
      clear_mem();
      reset_core(5);
      wait_trap("zero_trap", 500);
      check("zero_nfetch", fetch_q.size(), 32'd1);
      v = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_valid) v++;
      end
      check("zero_quiet", v, 32'd0);
      check("zero_trap_held", {31'd0, trap}, 32'd1);

      // Misaligned LW traps before any data request
      clear_mem();
      mem[0] = 32'h3fe00093;  // addi x1,x0,0x3fe
      mem[1] = 32'h0000a103;  // lw   x2,0(x1)
      reset_core(5);
      wait_trap("lw_mis_trap", 500);
      repeat (5) @(negedge clk);
      check("lw_mis_nreads",  rd_q.size(), 32'd0);
      check("lw_mis_nwrites", wr_data_q.size(), 32'd0);
      check("lw_mis_nfetch",  fetch_q.size(), 32'd2);

      // Reset dropped while a request is pending
      load_counter_prog();
      reset_core(5);
      wait_writes("mid_run", 2, 3000);
      resp_en = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_pending", {31'd0, mem_valid}, 32'd1);
      #1 resetn = 1'b0;
      #1;
      check("mid_valid", {31'd0, mem_valid}, 32'd0);
      check("mid_addr",  mem_addr, 32'd0);
      check("mid_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("mid_instr", {31'd0, mem_instr}, 32'd0);
      load_counter_prog();
      clear_logs();
      resp_en = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      wait_writes("mid_restart", 1, 3000);
      check("mid_refetch", fetch_q[0], 32'h0);
      check("mid_first_wdata", wr_data_q[0], 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
